acc_offload_responder: RTL and testbench

- Accelerator-side receiver for scalar-core instruction offload. It is the responder end of the core's accelerator dispatch port, facing the vector unit.
- Accepts offloaded instructions with their scalar operands and transaction IDs into a request queue, then issues them in order to the accelerator backend.
- Collects backend results in issue order and returns single-cycle writeback responses tagged with the original transaction ID.

---
 rtl/acc_offload_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_acc_offload_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_offload_responder.sv
// acc_offload_responder
// Accelerator-side end of the scalar core's offload port. Requests are
// buffered in a small FIFO, issued in order to the backend, and the backend's
// in-order results are returned as single-cycle writeback pulses carrying the
// original transaction ID.
module acc_offload_responder #(
    parameter int XLEN         = 64,
    parameter int TransIdWidth = 3,
    parameter int ReqDepth     = 4,
    parameter int MaxInflight  = 7
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [31:0]                      req_insn_i,
    input  logic [XLEN-1:0]                  req_rs1_i,
    input  logic [XLEN-1:0]                  req_rs2_i,
    input  logic [TransIdWidth-1:0]          req_trans_id_i,
    input  logic                             flush_i,
    output logic                             exe_valid_o,
    input  logic                             exe_ready_i,
    output logic [31:0]                      exe_insn_o,
    output logic [XLEN-1:0]                  exe_rs1_o,
    output logic [XLEN-1:0]                  exe_rs2_o,
    input  logic                             res_valid_i,
    input  logic [XLEN-1:0]                  res_data_i,
    input  logic                             res_error_i,
    output logic                             resp_valid_o,
    output logic [XLEN-1:0]                  resp_result_o,
    output logic                             resp_error_o,
    output logic [TransIdWidth-1:0]          resp_trans_id_o,
    output logic [$clog2(MaxInflight+1)-1:0] inflight_o,
    output logic                             busy_o,
    output logic                             proto_err_o
);

    localparam int QAW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
    localparam int QCW = $clog2(ReqDepth + 1);
    localparam int TAW = (MaxInflight > 1) ? $clog2(MaxInflight) : 1;
    localparam int ICW = $clog2(MaxInflight + 1);

    // Request-queue pointer increment, wrapping at ReqDepth.
    function automatic logic [QAW-1:0] q_ptr_inc(input logic [QAW-1:0] p);
        if (p == QAW'(ReqDepth - 1)) begin
            q_ptr_inc = {QAW{1'b0}};
        end else begin
            q_ptr_inc = p + QAW'(1);
        end
    endfunction

    // Tag-FIFO pointer increment, wrapping at MaxInflight (need not be a power of two).
    function automatic logic [TAW-1:0] t_ptr_inc(input logic [TAW-1:0] p);
        if (p == TAW'(MaxInflight - 1)) begin
            t_ptr_inc = {TAW{1'b0}};
        end else begin
            t_ptr_inc = p + TAW'(1);
        end
    endfunction

    // Request queue storage and bookkeeping
    logic [31:0]             r_q_insn [ReqDepth];
    logic [XLEN-1:0]         r_q_rs1  [ReqDepth];
    logic [XLEN-1:0]         r_q_rs2  [ReqDepth];
    logic [TransIdWidth-1:0] r_q_tid  [ReqDepth];
    logic [QAW-1:0]          r_q_wptr;
    logic [QAW-1:0]          r_q_rptr;
    logic [QCW-1:0]          r_q_cnt;

    // Tag FIFO of issued-but-unanswered transaction IDs; its fill level is the inflight count
    logic [TransIdWidth-1:0] r_t_mem [MaxInflight];
    logic [TAW-1:0]          r_t_wptr;
    logic [TAW-1:0]          r_t_rptr;
    logic [ICW-1:0]          r_inflight;

    // Writeback response registers
    logic                    r_resp_valid;
    logic [XLEN-1:0]         r_resp_result;
    logic                    r_resp_error;
    logic [TransIdWidth-1:0] r_resp_tid;
    logic                    r_proto_err;

    logic                    w_q_empty;
    logic                    w_q_full;
    logic                    w_ready;
    logic                    w_push;
    logic                    w_exe_valid;
    logic                    w_issue;
    logic                    w_tags_any;
    logic                    w_res_accept;
    logic                    w_bypass;
    logic                    w_t_push;
    logic                    w_t_pop;
    logic [TransIdWidth-1:0] w_res_tid;
    logic                    w_proto_hit;
    logic [QCW-1:0]          w_q_cnt_nxt;
    logic [ICW-1:0]          w_inflight_nxt;

    // Handshake decode. A result that arrives with nothing inflight can only
    // retire the instruction issuing in that same cycle (bypass of the tag FIFO).
    always_comb begin
        w_q_empty    = (r_q_cnt == {QCW{1'b0}});
        w_q_full     = (r_q_cnt == QCW'(ReqDepth));
        w_ready      = rst_ni && !w_q_full && !flush_i;
        w_push       = req_valid_i && w_ready;
        w_exe_valid  = !w_q_empty && (r_inflight < ICW'(MaxInflight)) && !flush_i;
        w_issue      = w_exe_valid && exe_ready_i;
        w_tags_any   = (r_inflight != {ICW{1'b0}});
        w_res_accept = res_valid_i && (w_tags_any || w_issue);
        w_bypass     = w_res_accept && !w_tags_any;
        w_t_push     = w_issue && !w_bypass;
        w_t_pop      = w_res_accept && !w_bypass;
        w_proto_hit  = res_valid_i && !w_res_accept;
        if (w_tags_any) begin
            w_res_tid = r_t_mem[r_t_rptr];
        end else begin
            w_res_tid = r_q_tid[r_q_rptr];
        end
    end

    // Next request-queue occupancy; flush empties it outright.
    always_comb begin
        w_q_cnt_nxt = r_q_cnt;
        if (flush_i) begin
            w_q_cnt_nxt = {QCW{1'b0}};
        end else if (w_push && !w_issue) begin
            w_q_cnt_nxt = r_q_cnt + QCW'(1);
        end else if (!w_push && w_issue) begin
            w_q_cnt_nxt = r_q_cnt - QCW'(1);
        end else begin
            w_q_cnt_nxt = r_q_cnt;
        end
    end

    // Next inflight count; simultaneous issue and retire cancel out.
    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_t_push && !w_t_pop) begin
            w_inflight_nxt = r_inflight + ICW'(1);
        end else if (!w_t_push && w_t_pop) begin
            w_inflight_nxt = r_inflight - ICW'(1);
        end else begin
            w_inflight_nxt = r_inflight;
        end
    end

    // Request queue: write on accept, advance head on issue, collapse on flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ReqDepth; i++) begin
                r_q_insn[i] <= 32'h0000_0000;
                r_q_rs1[i]  <= {XLEN{1'b0}};
                r_q_rs2[i]  <= {XLEN{1'b0}};
                r_q_tid[i]  <= {TransIdWidth{1'b0}};
            end
            r_q_wptr <= {QAW{1'b0}};
            r_q_rptr <= {QAW{1'b0}};
            r_q_cnt  <= {QCW{1'b0}};
        end else begin
            if (w_push) begin
                r_q_insn[r_q_wptr] <= req_insn_i;
                r_q_rs1[r_q_wptr]  <= req_rs1_i;
                r_q_rs2[r_q_wptr]  <= req_rs2_i;
                r_q_tid[r_q_wptr]  <= req_trans_id_i;
                r_q_wptr           <= q_ptr_inc(r_q_wptr);
            end
            if (flush_i) begin
                r_q_rptr <= r_q_wptr;
            end else if (w_issue) begin
                r_q_rptr <= q_ptr_inc(r_q_rptr);
            end
            r_q_cnt <= w_q_cnt_nxt;
        end
    end

    // Tag FIFO: record the ID of every issued instruction, release the oldest on each result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MaxInflight; i++) begin
                r_t_mem[i] <= {TransIdWidth{1'b0}};
            end
            r_t_wptr   <= {TAW{1'b0}};
            r_t_rptr   <= {TAW{1'b0}};
            r_inflight <= {ICW{1'b0}};
        end else begin
            if (w_t_push) begin
                r_t_mem[r_t_wptr] <= r_q_tid[r_q_rptr];
                r_t_wptr          <= t_ptr_inc(r_t_wptr);
            end
            if (w_t_pop) begin
                r_t_rptr <= t_ptr_inc(r_t_rptr);
            end
            r_inflight <= w_inflight_nxt;
        end
    end

    // Writeback pulse one cycle after an accepted result; data holds between pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resp_valid  <= 1'b0;
            r_resp_result <= {XLEN{1'b0}};
            r_resp_error  <= 1'b0;
            r_resp_tid    <= {TransIdWidth{1'b0}};
        end else begin
            r_resp_valid <= w_res_accept;
            if (w_res_accept) begin
                r_resp_result <= res_data_i;
                r_resp_error  <= res_error_i;
                r_resp_tid    <= w_res_tid;
            end
        end
    end

    // Sticky protocol error: a result with nothing to retire.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_proto_err <= 1'b0;
        end else if (w_proto_hit) begin
            r_proto_err <= 1'b1;
        end
    end

    assign req_ready_o     = w_ready;
    assign exe_valid_o     = w_exe_valid;
    assign exe_insn_o      = r_q_insn[r_q_rptr];
    assign exe_rs1_o       = r_q_rs1[r_q_rptr];
    assign exe_rs2_o       = r_q_rs2[r_q_rptr];
    assign resp_valid_o    = r_resp_valid;
    assign resp_result_o   = r_resp_result;
    assign resp_error_o    = r_resp_error;
    assign resp_trans_id_o = r_resp_tid;
    assign inflight_o      = r_inflight;
    assign busy_o          = !w_q_empty || (r_inflight != {ICW{1'b0}});
    assign proto_err_o     = r_proto_err;

endmodule

// File: tb/tb_acc_offload_responder.sv
// Self-checking bench for acc_offload_responder: directed scenarios plus a
// randomized phase, checked against a queue-level reference model.
module tb_acc_offload_responder;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_insn_i;
    logic [63:0] req_rs1_i;
    logic [63:0] req_rs2_i;
    logic [2:0]  req_trans_id_i;
    logic        flush_i;
    logic        exe_valid_o;
    logic        exe_ready_i;
    logic [31:0] exe_insn_o;
    logic [63:0] exe_rs1_o;
    logic [63:0] exe_rs2_o;
    logic        res_valid_i;
    logic [63:0] res_data_i;
    logic        res_error_i;
    logic        resp_valid_o;
    logic [63:0] resp_result_o;
    logic        resp_error_o;
    logic [2:0]  resp_trans_id_o;
    logic [2:0]  inflight_o;
    logic        busy_o;
    logic        proto_err_o;

    acc_offload_responder #(
        .XLEN(64), .TransIdWidth(3), .ReqDepth(4), .MaxInflight(7)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_insn_i(req_insn_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
        .req_trans_id_i(req_trans_id_i), .flush_i(flush_i),
        .exe_valid_o(exe_valid_o), .exe_ready_i(exe_ready_i),
        .exe_insn_o(exe_insn_o), .exe_rs1_o(exe_rs1_o), .exe_rs2_o(exe_rs2_o),
        .res_valid_i(res_valid_i), .res_data_i(res_data_i), .res_error_i(res_error_i),
        .resp_valid_o(resp_valid_o), .resp_result_o(resp_result_o),
        .resp_error_o(resp_error_o), .resp_trans_id_o(resp_trans_id_o),
        .inflight_o(inflight_o), .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] insn;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [2:0]  id;
    } req_t;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
        logic [2:0]  id;
    } resp_t;

    // Reference model: pending requests, issued IDs, expected writebacks.
    req_t  req_q[$];
    logic [2:0] tag_q[$];
    resp_t exp_resp_q[$];
    resp_t last_resp;
    logic  proto_m;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + model: mid-cycle, compare DUT against the model, then advance
    // the model with the inputs that the next rising edge will sample.
    always @(negedge clk_i) begin
        bit    ready_m;
        bit    ev_m;
        req_t  h;
        resp_t e;
        if (!rst_ni) begin
            req_q.delete();
            tag_q.delete();
            exp_resp_q.delete();
            last_resp = '0;
            proto_m   = 1'b0;
        end else begin
            ready_m = (req_q.size() < 4) && !flush_i;
            ev_m    = (req_q.size() > 0) && (tag_q.size() < 7) && !flush_i;
            chk("req_ready", 64'(req_ready_o), 64'(ready_m));
            chk("exe_valid", 64'(exe_valid_o), 64'(ev_m));
            if (ev_m) begin
                h = req_q[0];
                chk("exe_insn", 64'(exe_insn_o), 64'(h.insn));
                chk("exe_rs1", exe_rs1_o, h.rs1);
                chk("exe_rs2", exe_rs2_o, h.rs2);
            end
            chk("inflight", 64'(inflight_o), 64'(tag_q.size()));
            chk("busy", 64'(busy_o), 64'((req_q.size() > 0) || (tag_q.size() > 0)));
            chk("proto_err", 64'(proto_err_o), 64'(proto_m));
            chk("resp_valid", 64'(resp_valid_o), 64'(exp_resp_q.size() > 0));
            if (exp_resp_q.size() > 0) begin
                e = exp_resp_q.pop_front();
                last_resp = e;
            end
            chk("resp_result", resp_result_o, last_resp.data);
            chk("resp_error", 64'(resp_error_o), 64'(last_resp.err));
            chk("resp_id", 64'(resp_trans_id_o), 64'(last_resp.id));
            // advance the model
            if (req_valid_i && ready_m) begin
                req_q.push_back('{req_insn_i, req_rs1_i, req_rs2_i, req_trans_id_i});
            end
            if (ev_m && exe_ready_i) begin
                h = req_q.pop_front();
                tag_q.push_back(h.id);
            end
            if (res_valid_i) begin
                if (tag_q.size() > 0) begin
                    exp_resp_q.push_back('{res_data_i, res_error_i, tag_q.pop_front()});
                end else begin
                    proto_m = 1'b1;
                end
            end
            if (flush_i) begin
                req_q.delete();
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        req_valid_i = 1'b0; req_insn_i = 32'h0; req_rs1_i = 64'h0; req_rs2_i = 64'h0;
        req_trans_id_i = 3'h0; flush_i = 1'b0; exe_ready_i = 1'b0;
        res_valid_i = 1'b0; res_data_i = 64'h0; res_error_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd0);
        chk({tag, "_exe_valid"}, 64'(exe_valid_o), 64'd0);
        chk({tag, "_exe_insn"}, 64'(exe_insn_o), 64'd0);
        chk({tag, "_exe_rs1"}, exe_rs1_o, 64'd0);
        chk({tag, "_exe_rs2"}, exe_rs2_o, 64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid_o), 64'd0);
        chk({tag, "_resp_result"}, resp_result_o, 64'd0);
        chk({tag, "_resp_error"}, 64'(resp_error_o), 64'd0);
        chk({tag, "_resp_id"}, 64'(resp_trans_id_o), 64'd0);
        chk({tag, "_inflight"}, 64'(inflight_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_proto_err"}, 64'(proto_err_o), 64'd0);
    endtask

    // Offer one request until accepted (bounded).
    task automatic push(input logic [31:0] insn, input logic [63:0] rs1,
                        input logic [63:0] rs2, input logic [2:0] id);
        bit acc = 1'b0;
        int tries = 0;
        while (!acc && tries < 50) begin
            req_valid_i = 1'b1; req_insn_i = insn; req_rs1_i = rs1;
            req_rs2_i = rs2; req_trans_id_i = id;
            #1;
            acc = req_ready_o;
            step();
            tries++;
        end
        req_valid_i = 1'b0;
        chk("push_accepted", 64'(acc), 64'd1);
    endtask

    // Return results for everything outstanding and let the queue empty (bounded).
    task automatic drain();
        int cyc = 0;
        req_valid_i = 1'b0; flush_i = 1'b0; exe_ready_i = 1'b1;
        while ((req_q.size() > 0 || tag_q.size() > 0 || exp_resp_q.size() > 0) && cyc < 200) begin
            res_valid_i = (tag_q.size() > 0);
            res_data_i  = {$urandom, $urandom};
            res_error_i = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        res_valid_i = 1'b0;
        chk("drain_done", 64'(cyc < 200), 64'd1);
    endtask

    function automatic logic [31:0] insn_of(input int k);
        return 32'h0000_0057 | (32'(k) << 7);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0;
        idle();
        step();
        check_all_zero("reset");
        step();
        rst_ni = 1'b1;
        step();

        // single request round trip
        req_valid_i = 1'b1; req_insn_i = 32'h0000_0057; req_rs1_i = 64'd5;
        req_rs2_i = 64'd0; req_trans_id_i = 3'd3; exe_ready_i = 1'b1;
        #1;
        chk("t1_ready", 64'(req_ready_o), 64'd1);
        chk("t1_no_bypass", 64'(exe_valid_o), 64'd0);
        step();
        req_valid_i = 1'b0;
        #1;
        chk("t1_exe_valid", 64'(exe_valid_o), 64'd1);
        chk("t1_exe_insn", 64'(exe_insn_o), 64'h57);
        chk("t1_exe_rs1", exe_rs1_o, 64'd5);
        step();
        step();
        res_valid_i = 1'b1; res_data_i = 64'hA5; res_error_i = 1'b0;
        step();
        res_valid_i = 1'b0;
        #1;
        chk("t1_resp_valid", 64'(resp_valid_o), 64'd1);
        chk("t1_resp_result", resp_result_o, 64'hA5);
        chk("t1_resp_id", 64'(resp_trans_id_o), 64'd3);
        chk("t1_inflight", 64'(inflight_o), 64'd0);
        step();
        #1;
        chk("t1_single_pulse", 64'(resp_valid_o), 64'd0);
        step();

        // fill queue with backend stalled
        exe_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) push(insn_of(k), 64'(k), ~64'(k), 3'(k));
        req_valid_i = 1'b1; req_insn_i = insn_of(4); req_trans_id_i = 3'd4;
        #1;
        chk("t2_full_ready", 64'(req_ready_o), 64'd0);
        step();
        req_valid_i = 1'b0;
        exe_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_issue_valid", 64'(exe_valid_o), 64'd1);
            chk("t2_issue_order", 64'(exe_insn_o), 64'(insn_of(k)));
            step();
        end
        drain();

        // inflight limit
        exe_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) push(insn_of(k + 8), 64'(k), 64'(k), 3'(k));
        step(); step(); step();
        chk("t3_inflight_max", 64'(inflight_o), 64'd7);
        chk("t3_exe_blocked", 64'(exe_valid_o), 64'd0);
        res_valid_i = 1'b1; res_data_i = 64'h1234;
        step();
        res_valid_i = 1'b0;
        #1;
        chk("t3_eighth_valid", 64'(exe_valid_o), 64'd1);
        step();
        chk("t3_inflight_refill", 64'(inflight_o), 64'd7);
        drain();

        // flush with 2 inflight and 3 queued
        exe_ready_i = 1'b1;
        push(insn_of(1), 64'd1, 64'd1, 3'd1);
        push(insn_of(2), 64'd2, 64'd2, 3'd2);
        step();
        exe_ready_i = 1'b0;
        for (int k = 3; k < 6; k++) push(insn_of(k), 64'(k), 64'(k), 3'(k));
        chk("t4_inflight", 64'(inflight_o), 64'd2);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0; exe_ready_i = 1'b1;
        #1;
        chk("t4_no_issue", 64'(exe_valid_o), 64'd0);
        chk("t4_busy", 64'(busy_o), 64'd1);
        res_valid_i = 1'b1; res_data_i = 64'hF1;
        step();
        res_data_i = 64'hF2;
        chk("t4_resp1_id", 64'(resp_trans_id_o), 64'd1);
        step();
        res_valid_i = 1'b0;
        #1;
        chk("t4_resp2_valid", 64'(resp_valid_o), 64'd1);
        chk("t4_resp2_id", 64'(resp_trans_id_o), 64'd2);
        chk("t4_busy_clear", 64'(busy_o), 64'd0);
        step();

        // simultaneous issue and result at inflight 2
        exe_ready_i = 1'b1;
        push(insn_of(10), 64'd10, 64'd0, 3'd6);
        push(insn_of(11), 64'd11, 64'd0, 3'd7);
        step();
        exe_ready_i = 1'b0;
        push(insn_of(12), 64'd12, 64'd0, 3'd5);
        chk("t5_inflight_pre", 64'(inflight_o), 64'd2);
        exe_ready_i = 1'b1; res_valid_i = 1'b1; res_data_i = 64'h5555;
        step();
        exe_ready_i = 1'b0; res_valid_i = 1'b0;
        #1;
        chk("t5_inflight_same", 64'(inflight_o), 64'd2);
        chk("t5_resp_oldest", 64'(resp_trans_id_o), 64'd6);
        drain();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            req_valid_i    = ($urandom_range(0, 99) < 60);
            req_insn_i     = $urandom;
            req_rs1_i      = {$urandom, $urandom};
            req_rs2_i      = {$urandom, $urandom};
            req_trans_id_i = 3'($urandom_range(0, 7));
            exe_ready_i    = ($urandom_range(0, 99) < 70);
            res_valid_i    = (tag_q.size() > 0) && ($urandom_range(0, 99) < 45);
            res_data_i     = {$urandom, $urandom};
            res_error_i    = 1'($urandom_range(0, 1));
            flush_i        = ($urandom_range(0, 99) < 4);
            step();
        end
        drain();

        // result with nothing inflight
        idle();
        res_valid_i = 1'b1; res_data_i = 64'hDEAD;
        step();
        res_valid_i = 1'b0;
        #1;
        chk("t6_no_resp", 64'(resp_valid_o), 64'd0);
        chk("t6_proto_set", 64'(proto_err_o), 64'd1);
        step(); step(); step();
        chk("t6_proto_sticky", 64'(proto_err_o), 64'd1);

        // asynchronous reset mid-stream
        exe_ready_i = 1'b0;
        push(insn_of(20), 64'd20, 64'd20, 3'd2);
        push(insn_of(21), 64'd21, 64'd21, 3'd3);
        rst_ni = 1'b0;
        #1;
        check_all_zero("midreset");
        step();
        step();
        rst_ni = 1'b1;
        step();
        chk("t6_proto_cleared", 64'(proto_err_o), 64'd0);
        chk("t6_idle_after_reset", 64'(busy_o), 64'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
